// File: rtl/gate16_bist.sv
// ---------------------------------------------------------------------------
// gate16_bist
//   Built-in self-test engine for an external 16-bit bitwise gate datapath
//   (Not16 / And16 / Or16). Two independent 16-bit LFSRs produce one operand
//   pair per clock. The datapath under test is combinational, so its results
//   are compared against the expected ~a, a&b and a|b in the same cycle the
//   operands are presented. Mismatching vectors are counted, the index of the
//   first bad vector is recorded, and pass/fail is reported at the end of a
//   run.
//
// Parameters
//   NUM_VECTORS    vectors applied per run (1..65535)
//   SEED_A/SEED_B  initial LFSR values; a zero seed is replaced by 16'h0001
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous reset, active low
//   start          one-cycle run request, honoured in IDLE and DONE only
//   busy           high while vectors are being applied
//   done           high once a run has completed, until next start/reset
//   pass           valid with done; 1 when no vector mismatched
//   a, b           registered operands driven to the datapath under test
//   dut_not/and/or datapath results for the current a/b
//   err_count      mismatching vectors in the current/last run (saturating)
//   first_err_idx  index of the first mismatching vector, 16'hFFFF if none
//   signature      (only with GATE16_BIST_MISR_EN) MISR over all results
//
// Build option
//   GATE16_BIST_MISR_EN  adds the signature output and its MISR register.
// ---------------------------------------------------------------------------
module gate16_bist #(
    parameter int          NUM_VECTORS = 256,
    parameter logic [15:0] SEED_A      = 16'hACE1,
    parameter logic [15:0] SEED_B      = 16'h1234
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] a,
    output logic [15:0] b,
    input  logic [15:0] dut_not,
    input  logic [15:0] dut_and,
    input  logic [15:0] dut_or,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx
`ifdef GATE16_BIST_MISR_EN
    ,
    output logic [15:0] signature
`endif
);

    // An all-zero LFSR state never leaves zero, so such a seed is remapped.
    localparam logic [15:0] L_SEED_A   = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
    localparam logic [15:0] L_SEED_B   = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;
    localparam logic [15:0] L_LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] L_NO_ERR   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_idx;
    logic [15:0] r_err_count;
    logic [15:0] r_first_err_idx;

    logic        w_mismatch;
    logic [15:0] w_err_next;
    logic [15:0] w_first_next;

    // Same-cycle compare: the datapath is combinational from a/b.
    always_comb begin
        w_mismatch = (dut_not != ~r_a)
                   | (dut_and != (r_a & r_b))
                   | (dut_or  != (r_a | r_b));
    end

    // Counter saturates so it can never wrap back to a "clean" value.
    always_comb begin
        w_err_next = r_err_count;
        if (w_mismatch && (r_err_count != 16'hFFFF)) begin
            w_err_next = r_err_count + 16'd1;
        end
    end

    // Only the first failing index is latched; later failures leave it alone.
    always_comb begin
        w_first_next = r_first_err_idx;
        if (w_mismatch && (r_first_err_idx == L_NO_ERR)) begin
            w_first_next = r_idx;
        end
    end

`ifdef GATE16_BIST_MISR_EN
    logic [15:0] r_signature;
    logic [15:0] w_sig_next;

    always_comb begin
        w_sig_next = lfsr_step(r_signature) ^ dut_not ^ dut_and ^ dut_or;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signature <= 16'h0000;
        end else begin
            if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
                r_signature <= 16'h0000;
            end else if (r_state == S_RUN) begin
                r_signature <= w_sig_next;
            end
        end
    end

    assign signature = r_signature;
`endif

    // Control FSM with all status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_a             <= 16'h0000;
            r_b             <= 16'h0000;
            r_idx           <= 16'h0000;
            r_err_count     <= 16'h0000;
            r_first_err_idx <= L_NO_ERR;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Restart from DONE behaves exactly like a start from IDLE.
                    if (start) begin
                        r_state         <= S_RUN;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                        r_a             <= L_SEED_A;
                        r_b             <= L_SEED_B;
                        r_idx           <= 16'h0000;
                        r_err_count     <= 16'h0000;
                        r_first_err_idx <= L_NO_ERR;
                    end
                end
                S_RUN: begin
                    // start is deliberately ignored here.
                    r_err_count     <= w_err_next;
                    r_first_err_idx <= w_first_next;
                    if (r_idx == L_LAST_IDX) begin
                        // Operands hold the last vector while in DONE.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 16'h0000);
                    end else begin
                        r_a   <= lfsr_step(r_a);
                        r_b   <= lfsr_step(r_b);
                        r_idx <= r_idx + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign a             = r_a;
    assign b             = r_b;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_gate16_bist.sv
// Bench for gate16_bist: two instances (default seeds, and zero seeds),
// both with NUM_VECTORS=8. The gate datapath for instance 0 can have
// and[0] stuck at 0 to produce a known failure pattern.
module tb_gate16_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start0, start1, stuck;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] a0, b0, err0, fidx0, n0, an0, o0;
    logic [15:0] a1, b1, err1, fidx1, n1, an1, o1;
`ifdef GATE16_BIST_MISR_EN
    logic [15:0] sig0, sig1;
`endif

    assign n0  = ~a0;
    assign an0 = (a0 & b0) & ~{15'h0000, stuck};
    assign o0  = a0 | b0;
    assign n1  = ~a1;
    assign an1 = a1 & b1;
    assign o1  = a1 | b1;

    gate16_bist #(.NUM_VECTORS(8), .SEED_A(16'hACE1), .SEED_B(16'h1234)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .pass(pass0), .a(a0), .b(b0), .dut_not(n0), .dut_and(an0), .dut_or(o0),
        .err_count(err0), .first_err_idx(fidx0)
`ifdef GATE16_BIST_MISR_EN
        , .signature(sig0)
`endif
    );

    gate16_bist #(.NUM_VECTORS(8), .SEED_A(16'h0000), .SEED_B(16'h0000)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .a(a1), .b(b1), .dut_not(n1), .dut_and(an1), .dut_or(o1),
        .err_count(err1), .first_err_idx(fidx1)
`ifdef GATE16_BIST_MISR_EN
        , .signature(sig1)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [15:0] err;
        logic [15:0] fidx;
        logic        pass;
    } run_t;

    vec_t        vt[8];
    run_t        rt[3];
    logic [15:0] gold_sig;

    function automatic logic [15:0] step(input logic [15:0] v);
        step = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // Runs from vector 0 until busy drops, checking each vector's operands.
    task automatic run_vectors(output int cyc);
        cyc = 0;
        while (busy0 && cyc < 100) begin
            if (cyc < 8) begin
                chk($sformatf("a[%0d]", cyc), a0, vt[cyc].a);
                chk($sformatf("b[%0d]", cyc), b0, vt[cyc].b);
            end
            cyc++;
            tick();
        end
    endtask

    task automatic chk_reset0;
        chk("rst busy", {15'h0, busy0}, 16'h0);
        chk("rst done", {15'h0, done0}, 16'h0);
        chk("rst pass", {15'h0, pass0}, 16'h0);
        chk("rst a", a0, 16'h0000);
        chk("rst b", b0, 16'h0000);
        chk("rst err", err0, 16'h0000);
        chk("rst fidx", fidx0, 16'hFFFF);
`ifdef GATE16_BIST_MISR_EN
        chk("rst sig", sig0, 16'h0000);
`endif
    endtask

    initial begin
        int cyc;
        int cnt;
        logic [15:0] s;

        // Vector table: the first two entries are hand-computed.
        vt[0] = '{16'hACE1, 16'h1234};
        vt[1] = '{16'h59C3, 16'h2469};
        for (int i = 2; i < 8; i++) begin
            vt[i].a = step(vt[i-1].a);
            vt[i].b = step(vt[i-1].b);
        end
        cnt = 0;
        s   = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (vt[i].a[0] & vt[i].b[0]) cnt++;
            s = step(s) ^ ~vt[i].a ^ (vt[i].a & vt[i].b) ^ (vt[i].a | vt[i].b);
        end
        gold_sig = s;

        // Back-to-back runs: golden, stuck-at, golden again.
        rt[0] = '{1'b0, 16'd0, 16'hFFFF, 1'b1};
        rt[1] = '{1'b1, 16'(cnt), 16'd1, 1'b0};
        rt[2] = '{1'b0, 16'd0, 16'hFFFF, 1'b1};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; stuck = 1'b0;
        #12;
        chk_reset0();
        chk("rst busy1", {15'h0, busy1}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 3; r++) begin
            stuck = rt[r].fault;
            pulse_start0();
            chk($sformatf("run%0d busy", r), {15'h0, busy0}, 16'h1);
            chk($sformatf("run%0d done drop", r), {15'h0, done0}, 16'h0);
            run_vectors(cyc);
            chk($sformatf("run%0d busy cycles", r), 16'(cyc), 16'd8);
            chk($sformatf("run%0d done", r), {15'h0, done0}, 16'h1);
            chk($sformatf("run%0d pass", r), {15'h0, pass0}, {15'h0, rt[r].pass});
            chk($sformatf("run%0d err", r), err0, rt[r].err);
            chk($sformatf("run%0d fidx", r), fidx0, rt[r].fidx);
            chk($sformatf("run%0d a hold", r), a0, vt[7].a);
`ifdef GATE16_BIST_MISR_EN
            if (!rt[r].fault) chk($sformatf("run%0d sig", r), sig0, gold_sig);
`endif
            tick();
            chk($sformatf("run%0d done stable", r), {15'h0, done0}, 16'h1);
        end
        stuck = 1'b0;

        // start pulsed during RUN cycle 3 is ignored.
        pulse_start0();
        cyc = 0;
        while (busy0 && cyc < 100) begin
            start0 = (cyc == 3);
            cyc++;
            tick();
        end
        start0 = 1'b0;
        chk("ign busy cycles", 16'(cyc), 16'd8);
        chk("ign done", {15'h0, done0}, 16'h1);
        chk("ign pass", {15'h0, pass0}, 16'h1);

        // Reset at RUN cycle 4, then a fresh run starts from vector 0.
        stuck = 1'b1;
        pulse_start0();
        repeat (4) tick();
        chk("mid err before rst", err0, 16'(((vt[1].a[0] & vt[1].b[0]) ? 1 : 0)
                                         + ((vt[2].a[0] & vt[2].b[0]) ? 1 : 0)
                                         + ((vt[3].a[0] & vt[3].b[0]) ? 1 : 0)));
        rst_n = 1'b0;
        #2;
        chk_reset0();
        @(negedge clk);
        rst_n = 1'b1;
        stuck = 1'b0;
        pulse_start0();
        chk("rerun a0", a0, 16'hACE1);
        chk("rerun err", err0, 16'h0000);
        run_vectors(cyc);
        chk("rerun cycles", 16'(cyc), 16'd8);
        chk("rerun pass", {15'h0, pass0}, 16'h1);

        // Zero seeds are remapped to 1.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("zs a", a1, 16'h0001);
        chk("zs b", b1, 16'h0001);
        cyc = 0;
        while (busy1 && cyc < 100) begin
            cyc++;
            tick();
        end
        chk("zs cycles", 16'(cyc), 16'd8);
        chk("zs done", {15'h0, done1}, 16'h1);
        chk("zs pass", {15'h0, pass1}, 16'h1);
        chk("zs fidx", fidx1, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
